cycle_detector: RTL and testbench

//  Detects entry of a gene-network state trajectory x[t] into an attractor.

---
 rtl/cycle_detector.sv | 162 ++++++++++++++++
 tb/tb_cycle_detector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cycle_detector.sv
// Attractor detector: matches each new state against a shift-register history.
// Optional no-attractor timeout is built only when CYCLE_DET_TIMEOUT_EN is defined.
module cycle_detector #(
    parameter int N       = 8,
    parameter int DEPTH   = 8,
    parameter int WARMUP  = 2,
    parameter int SW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init_chg,
    input  logic                       x_valid,
    input  logic [N-1:0]               x,
    output logic                       flag,
    output logic                       fixed,
    output logic [$clog2(DEPTH+1)-1:0] period,
    output logic                       locked,
    output logic [SW-1:0]              onset,
    output logic                       timeout
);

    localparam int PW = $clog2(DEPTH+1);

    logic [N-1:0]   hist_q [1:DEPTH];
    logic [N-1:0]   hist_d [1:DEPTH];
    logic [DEPTH:1] valid_q, valid_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  period_q, period_d;
    logic           flag_q, flag_d;
    logic           fixed_q, fixed_d;
    logic           locked_q, locked_d;
    logic [SW-1:0]  onset_q, onset_d;

    logic           accept;
    logic           det_en;
    logic [PW-1:0]  hit;

    assign accept = x_valid & ~init_chg;
    assign det_en = 32'(cnt_q) >= WARMUP;

    // Scan from the deepest entry so the smallest matching k is kept.
    always_comb begin
        hit = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (valid_q[k] && (hist_q[k] == x)) begin
                hit = PW'(k);
            end
        end
    end

    always_comb begin
        hist_d   = hist_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        flag_d   = flag_q;
        fixed_d  = fixed_q;
        locked_d = locked_q;
        onset_d  = onset_q;
        if (init_chg) begin
            for (int k = 1; k <= DEPTH; k++) begin
                hist_d[k] = '0;
            end
            valid_d  = '0;
            cnt_d    = '0;
            period_d = '0;
            flag_d   = 1'b0;
            fixed_d  = 1'b0;
            locked_d = 1'b0;
            onset_d  = '0;
        end else if (x_valid) begin
            hist_d[1]  = x;
            valid_d[1] = 1'b1;
            for (int k = 2; k <= DEPTH; k++) begin
                hist_d[k]  = hist_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
            if (cnt_q != {SW{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
            period_d = det_en ? hit : '0;
            fixed_d  = det_en && (hit == PW'(1));
            flag_d   = det_en && (hit >= PW'(2));
            if (det_en && (hit != '0) && !locked_q) begin
                locked_d = 1'b1;
                onset_d  = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                hist_q[k] <= '0;
            end
            valid_q  <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            flag_q   <= 1'b0;
            fixed_q  <= 1'b0;
            locked_q <= 1'b0;
            onset_q  <= '0;
        end else begin
            hist_q   <= hist_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            flag_q   <= flag_d;
            fixed_q  <= fixed_d;
            locked_q <= locked_d;
            onset_q  <= onset_d;
        end
    end

    assign flag   = flag_q;
    assign fixed  = fixed_q;
    assign period = period_q;
    assign locked = locked_q;
    assign onset  = onset_q;

`ifdef CYCLE_DET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timeout_q, timeout_d;

    // A lock on the same sample suppresses the timeout.
    always_comb begin
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
        if (init_chg) begin
            tcnt_d    = '0;
            timeout_d = 1'b0;
        end else if (accept && !locked_q) begin
            if (tcnt_q != TW'(TIMEOUT)) begin
                tcnt_d = tcnt_q + 1'b1;
            end
            if (!locked_d && (tcnt_d == TW'(TIMEOUT))) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT > 0) & accept;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cycle_detector.sv
// Directed bench for cycle_detector: one DEPTH=8 instance (TIMEOUT=6)
// and one DEPTH=4 instance sharing the same stimulus.
module tb_cycle_detector;

    logic       clk;
    logic       rst;
    logic       init_chg;
    logic       x_valid;
    logic [7:0] x;

    logic       a_flag, a_fixed, a_locked, a_timeout;
    logic [3:0] a_period;
    logic [7:0] a_onset;
    logic       b_flag, b_fixed, b_locked, b_timeout;
    logic [2:0] b_period;
    logic [7:0] b_onset;

    int n_checks;
    int n_err;

    cycle_detector #(
        .N(8), .DEPTH(8), .WARMUP(2), .SW(8), .TIMEOUT(6)
    ) u_a (
        .clk(clk), .rst(rst), .init_chg(init_chg),
        .x_valid(x_valid), .x(x),
        .flag(a_flag), .fixed(a_fixed), .period(a_period),
        .locked(a_locked), .onset(a_onset), .timeout(a_timeout)
    );

    cycle_detector #(
        .N(8), .DEPTH(4), .WARMUP(2), .SW(8), .TIMEOUT(64)
    ) u_b (
        .clk(clk), .rst(rst), .init_chg(init_chg),
        .x_valid(x_valid), .x(x),
        .flag(b_flag), .fixed(b_fixed), .period(b_period),
        .locked(b_locked), .onset(b_onset), .timeout(b_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] v);
        x       = v;
        x_valid = 1'b1;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic restart();
        init_chg = 1'b1;
        @(posedge clk);
        #1;
        init_chg = 1'b0;
    endtask

    task automatic hard_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, ".flag"},    32'(a_flag),    0);
        check({tag, ".fixed"},   32'(a_fixed),   0);
        check({tag, ".period"},  32'(a_period),  0);
        check({tag, ".locked"},  32'(a_locked),  0);
        check({tag, ".onset"},   32'(a_onset),   0);
        check({tag, ".timeout"}, 32'(a_timeout), 0);
    endtask

    logic [7:0] seq3 [12];
    logic [31:0] exp_to;

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b0;
        init_chg = 1'b0;
        x_valid  = 1'b0;
        x        = '0;
        seq3 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd1,
                 8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd2};
        repeat (2) @(posedge clk);
        #1;
        check_a_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // period-2 cycle
        send(8'h11);
        send(8'h22);
        send(8'h33);
        check("t1.p3", 32'(a_period), 0);
        check("t1.l3", 32'(a_locked), 0);
        send(8'h22);
        check("t1.period", 32'(a_period), 2);
        check("t1.flag",   32'(a_flag),   1);
        check("t1.fixed",  32'(a_fixed),  0);
        check("t1.locked", 32'(a_locked), 1);
        check("t1.onset",  32'(a_onset),  3);
        check("t1.to",     32'(a_timeout), 0);
        @(posedge clk);
        #1;
        check("t1.hold", 32'(a_period), 2);

        // init_chg beats x_valid
        init_chg = 1'b1;
        x_valid  = 1'b1;
        x        = 8'h22;
        @(posedge clk);
        #1;
        init_chg = 1'b0;
        x_valid  = 1'b0;
        check_a_zero("t4");
        send(8'h22);
        check("t4.period", 32'(a_period), 0);
        check("t4.locked", 32'(a_locked), 0);

        // fixed point, warmup
        restart();
        send(8'h05);
        send(8'h05);
        check("t2.w.period", 32'(a_period), 0);
        check("t2.w.fixed",  32'(a_fixed),  0);
        check("t2.w.locked", 32'(a_locked), 0);
        send(8'h05);
        check("t2.period", 32'(a_period), 1);
        check("t2.fixed",  32'(a_fixed),  1);
        check("t2.flag",   32'(a_flag),   0);
        check("t2.onset",  32'(a_onset),  2);
        check("t2.b.period", 32'(b_period), 1);
        send(8'h05);
        check("t2.again", 32'(a_period), 1);
        check("t2.onset2", 32'(a_onset), 2);
        send(8'h77);
        check("t2.x.period", 32'(a_period), 0);
        check("t2.x.fixed",  32'(a_fixed),  0);
        check("t2.x.locked", 32'(a_locked), 1);
        check("t2.x.onset",  32'(a_onset),  2);

        // async reset without a clock edge
        restart();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h22);
        check("t5.pre", 32'(a_locked), 1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #2;
        check_a_zero("t5");
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(8'h22);
        check("t5.period", 32'(a_period), 0);
        check("t5.locked", 32'(a_locked), 0);

        // period 5: beyond DEPTH=4, within DEPTH=8
        hard_reset();
        for (int i = 0; i < 12; i++) begin
            send(seq3[i]);
            check($sformatf("t3.b.period%0d", i), 32'(b_period), 0);
            check($sformatf("t3.b.flag%0d", i),   32'(b_flag),   0);
            check($sformatf("t3.b.locked%0d", i), 32'(b_locked), 0);
            check($sformatf("t3.a.period%0d", i), 32'(a_period),
                  (i >= 5) ? 32'd5 : 32'd0);
            check($sformatf("t3.a.flag%0d", i), 32'(a_flag),
                  (i >= 5) ? 32'd1 : 32'd0);
        end
        check("t3.a.onset", 32'(a_onset), 5);

        // timeout
        hard_reset();
        for (int i = 0; i < 6; i++) begin
            send(8'(i));
            if (i == 4) check("t6.to5", 32'(a_timeout), 0);
        end
`ifdef CYCLE_DET_TIMEOUT_EN
        exp_to = 32'd1;
`else
        exp_to = 32'd0;
`endif
        check("t6.to", 32'(a_timeout), exp_to);
        check("t6.b.to", 32'(b_timeout), 0);
        check("t6.lock", 32'(a_locked), 0);

        // counter saturation
        restart();
        for (int i = 0; i < 300; i++) begin
            send((i % 2 == 0) ? 8'hA5 : 8'h5A);
        end
        check("sat.period", 32'(a_period), 2);
        check("sat.flag",   32'(a_flag),   1);
        check("sat.onset",  32'(a_onset),  2);
        check("sat.to",     32'(a_timeout), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
